// File: rtl/q_event_counter.sv
// rtl/q_event_counter.sv - synchronized Q-edge event counter with saturating count, sticky overflow and snapshot handshake (optional macro FALL_EDGE_COUNT_EN)
module q_event_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             q_in,
   input  logic             clr_cnt,
   input  logic             snap_req,
   input  logic             snap_ready,
   output logic             snap_valid,
   output logic [CNT_W-1:0] snap_data,
   output logic             ovf
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             s1;
   logic             s2;
   logic             q_d;
   logic [1:0]       arm_cnt;
   logic             armed;
   logic             rise_ev;
   logic             fall_ev;
   logic             event_hit;
   logic [CNT_W-1:0] count;
   state_t           state;
   state_t           state_next;
   logic             load;

   // Two-flop synchronizer for the asynchronous latch output, plus one delay stage for edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         q_d <= 1'b0;
      end else begin
         s1  <= q_in;
         s2  <= s1;
         q_d <= s2;
      end
   end

   // Arming delay: edges are ignored until the synchronizer pipeline holds real samples,
   // so a level already present at reset release becomes the baseline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         arm_cnt <= 2'd0;
      end else if (arm_cnt != 2'd3) begin
         arm_cnt <= arm_cnt + 2'd1;
      end
   end

   assign armed   = (arm_cnt == 2'd3);
   assign rise_ev = s2 & ~q_d & armed;
`ifdef FALL_EDGE_COUNT_EN
   assign fall_ev = ~s2 & q_d & armed;
`else
   assign fall_ev = 1'b0;
`endif
   // Rise and fall cannot coincide, so at most one increment per cycle
   assign event_hit = rise_ev | fall_ev;

   // Saturating counter with sticky overflow; clear takes priority over a same-cycle event
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr_cnt) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (event_hit) begin
         if (count == CNT_MAX) begin
            ovf <= 1'b1;
         end else begin
            count <= count + CNT_ONE;
         end
      end
   end

   // Snapshot FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Snapshot FSM next state: capture in IDLE, wait for acceptance in HOLD
   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (snap_req) begin
               load       = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (snap_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Snapshot register captures the count as it stands before this cycle's update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap_data <= '0;
      end else if (load) begin
         snap_data <= count;
      end
   end

   assign snap_valid = (state == HOLD);

endmodule

// File: tb/tb_q_event_counter.sv
// tb/tb_q_event_counter.sv - self-checking bench for q_event_counter at CNT_W=8 and CNT_W=4
module tb_q_event_counter;

`ifdef FALL_EDGE_COUNT_EN
   localparam int E = 2;
`else
   localparam int E = 1;
`endif

   typedef struct {
      int d8;
      int d4;
      int o8;
      int o4;
   } exp_t;

   typedef struct {
      int   pulses;
      bit   clr;
      exp_t x;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       q_in;
   logic       clr_cnt;
   logic       snap_req;
   logic       snap_ready;
   logic       snap_valid8;
   logic [7:0] snap_data8;
   logic       ovf8;
   logic       snap_valid4;
   logic [3:0] snap_data4;
   logic       ovf4;

   int   passed = 0;
   int   total  = 0;
   int   ev     = 0;
   exp_t sb[$];
   vec_t vecs[5];

   always #5 clk = ~clk;

   q_event_counter dut8 (
      .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr_cnt(clr_cnt), .snap_req(snap_req),
      .snap_ready(snap_ready), .snap_valid(snap_valid8), .snap_data(snap_data8), .ovf(ovf8)
   );

   q_event_counter #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .q_in(q_in), .clr_cnt(clr_cnt), .snap_req(snap_req),
      .snap_ready(snap_ready), .snap_valid(snap_valid4), .snap_data(snap_data4), .ovf(ovf4)
   );

   function automatic exp_t model(int e);
      exp_t r;
      r.d8 = (e > 255) ? 255 : e;
      r.o8 = (e > 255) ? 1 : 0;
      r.d4 = (e > 15) ? 15 : e;
      r.o4 = (e > 15) ? 1 : 0;
      return r;
   endfunction

   task automatic chk(string name, int act, int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d required %0d", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      q_in = 1'b1;
      repeat (4) tick();
      q_in = 1'b0;
      repeat (4) tick();
      ev += E;
   endtask

   task automatic do_clr();
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      ev = 0;
   endtask

   task automatic accept(string tag);
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      chk({tag, " valid_drop"}, int'(snap_valid8 | snap_valid4), 0);
   endtask

   task automatic pop_cmp(string tag);
      exp_t e;
      int   n = 0;
      while (!(snap_valid8 && snap_valid4) && n < 8) begin
         tick();
         n++;
      end
      chk({tag, " valid"}, int'(snap_valid8 & snap_valid4), 1);
      e = sb.pop_front();
      chk({tag, " data8"}, int'(snap_data8), e.d8);
      chk({tag, " data4"}, int'(snap_data4), e.d4);
      chk({tag, " ovf8"}, int'(ovf8), e.o8);
      chk({tag, " ovf4"}, int'(ovf4), e.o4);
   endtask

   task automatic do_snap(string tag, exp_t x);
      sb.push_back(x);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      pop_cmp(tag);
      accept(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t held;
      int   p;

      vecs[0] = '{5,  1'b0, '{5*E,  5*E, 0, 0}};
      vecs[1] = '{12, 1'b0, '{17*E, 15,  0, 1}};
      vecs[2] = '{1,  1'b1, '{E,    E,   0, 0}};
      vecs[3] = '{3,  1'b0, '{4*E,  4*E, 0, 0}};
      vecs[4] = '{0,  1'b1, '{0,    0,   0, 0}};

      rst_n = 1'b0; q_in = 1'b0; clr_cnt = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
      repeat (3) tick();
      chk("reset valid", int'(snap_valid8 | snap_valid4), 0);
      chk("reset data", int'(snap_data8) + int'(snap_data4), 0);
      chk("reset ovf", int'(ovf8 | ovf4), 0);
      rst_n = 1'b1;
      repeat (4) tick();

      // Table-driven counting, saturation, overflow and clear
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].clr) do_clr();
         for (int k = 0; k < vecs[i].pulses; k++) pulse();
         do_snap($sformatf("vec%0d", i), vecs[i].x);
      end

      // Held snapshot ignores requests and new events until accepted
      do_clr();
      pulse();
      pulse();
      held = model(ev);
      sb.push_back(held);
      snap_req = 1'b1;
      pulse();
      pulse();
      snap_req = 1'b0;
      pop_cmp("hold");
      accept("hold");
      do_snap("hold_new", '{held.d8 + 2*E, held.d4 + 2*E, 0, 0});

      // Clear and rising event in the same cycle, snapshot takes the pre-clear count
      do_clr();
      p = (E == 1) ? 7 : 3;
      for (int k = 0; k < p; k++) pulse();
      q_in = 1'b1;
      tick();
      tick();
      sb.push_back(model(ev));
      clr_cnt = 1'b1;
      snap_req = 1'b1;
      tick();
      clr_cnt = 1'b0;
      snap_req = 1'b0;
      ev = 0;
      chk("collide data8 pre", int'(snap_data8), p*E);
      pop_cmp("collide");
      accept("collide");
      q_in = 1'b0;
      repeat (4) tick();
      ev += E - 1;
      do_snap("collide_after", model(ev));

      // Reset while holding a snapshot aborts it
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      chk("abort valid_pre", int'(snap_valid8 & snap_valid4), 1);
      rst_n = 1'b0;
      q_in = 1'b1;
      tick();
      chk("abort valid", int'(snap_valid8 | snap_valid4), 0);
      chk("abort data", int'(snap_data8) + int'(snap_data4), 0);

      // Level high through reset release is baseline, not an event
      tick();
      rst_n = 1'b1;
      ev = 0;
      repeat (6) tick();
      do_snap("baseline", model(0));
      q_in = 1'b0;
      repeat (4) tick();
      ev += E - 1;
      q_in = 1'b1;
      repeat (4) tick();
      ev += 1;
      do_snap("baseline_rise", model(ev));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/q_event_counter.md
Q_EVENT_COUNTER -- requirements
Module: q_event_counter

Interface
REQ-001 Parameter CNT_W, default 8, width of the event counter and the snapshot bus.
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 q_in  input  1  latch Q output; asynchronous to clk.
REQ-005 clr_cnt  input  1  synchronous counter clear, active-high, one-cycle effect.
REQ-006 snap_req  input  1  snapshot request, sampled each cycle.
REQ-007 snap_ready  input  1  consumer accepts the snapshot.
REQ-008 snap_valid  output  1  snapshot held and valid.
REQ-009 snap_data  output  CNT_W  snapshotted count.
REQ-010 ovf  output  1  sticky overflow flag.

Function
REQ-011 q_in SHALL pass through a 2-flop synchronizer (s1, s2), and s2 SHALL be registered once more into q_d.
REQ-012 A rising event SHALL be s2 & ~q_d & armed; q_in high at the setup point of edge E1 SHALL increment the count at E3.
REQ-013 Each event SHALL increment the count by exactly 1; the count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-014 An event arriving while the count equals 2^CNT_W-1 SHALL set ovf; ovf SHALL stay set until clr_cnt or reset.
REQ-015 clr_cnt SHALL force count=0 and ovf=0 on the next edge; on a same-cycle event, clear wins and the event is dropped.
REQ-016 Snapshot FSM SHALL have two states: IDLE and HOLD.
REQ-017 IDLE with snap_req=1 SHALL load snap_data with the pre-update count of that cycle, set snap_valid=1 on the next edge and move to HOLD.
REQ-018 HOLD SHALL keep snap_data and snap_valid stable and SHALL ignore snap_req.
REQ-019 HOLD with snap_ready=1 SHALL drop snap_valid on the next edge and return to IDLE; snap_data keeps its last value.
REQ-020 snap_req with clr_cnt in the same cycle SHALL capture the pre-clear count.
REQ-021 Counting SHALL continue unaffected in both FSM states.

Reset
REQ-022 A clk edge with rst_n=0 SHALL set s1, s2, q_d, count, ovf, snap_data and snap_valid to 0, and the FSM to IDLE.
REQ-023 armed SHALL be 0 in reset and SHALL become 1 after 3 clk edges with rst_n=1; a q_in level already high then SHALL be treated as baseline and not counted.
REQ-024 Reset asserted in HOLD SHALL abort the snapshot: snap_valid=0 on that edge, with no acceptance required.

Configuration
REQ-025 Macro FALL_EDGE_COUNT_EN: when defined, s2 falling (~s2 & q_d & armed) SHALL also count as an event, under the same saturation, ovf and clear rules.
REQ-026 When FALL_EDGE_COUNT_EN is undefined, only rising events SHALL count, and falling edges SHALL have no effect.

Verification
REQ-027 Reset, then 5 q_in pulses each 4 cycles high and 4 cycles low -> count=5; the snapshot gives snap_data=5; ovf=0.
REQ-028 CNT_W=4, 17 pulses -> snap_data=15 and ovf=1; then clr_cnt plus 1 pulse -> snap_data=1 and ovf=0.
REQ-029 q_in held high through reset release -> no increment; q_in then falls and rises again -> count=1.
REQ-030 snap_req asserted with snap_ready=0 for 10 cycles while 2 pulses occur -> snap_data holds the first value; then snap_ready=1 -> snap_valid falls next edge, and a new request gives old+2.
REQ-031 clr_cnt and a rising event in the same cycle with count=7 -> count=0; snap_req in that cycle -> snap_data=7.
REQ-032 With FALL_EDGE_COUNT_EN defined, 3 full pulses -> count=6; without it, count=3.
